// File: rtl/fsm_serial_bit_receiver.sv
// Serial-to-parallel receiver: rebuilds an LSB-first DATA_W-bit frame, counts its ones,
// and aborts a frame with an error pulse when the idle gap between bits reaches TMO cycles.
module fsm_serial_bit_receiver #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4,
  parameter int TMO    = 15
) (
  input  logic              iclk,
  input  logic              irstn,
  input  logic              i_start,
  input  logic              i_valid,
  input  logic              i_sbit,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_bit_cnt,
  output logic              o_done,
  output logic              o_err,
  output logic              o_busy
);

  localparam int IW = $clog2(DATA_W);
  localparam int GW = (TMO > 1) ? $clog2(TMO) : 1;

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  state_t            state;
  logic [DATA_W-2:0] shift_q;
  logic [IW-1:0]     idx;
  logic [CNT_W-1:0]  ones;
  logic [GW-1:0]     gap;
  logic [DATA_W-1:0] shift_nxt;

  // Bit 0 of the architectural shift register is always shifted out before it is read,
  // so only the upper DATA_W-1 bits are stored; the full word exists only at capture.
  assign shift_nxt = {i_sbit, shift_q};

  always_ff @(posedge iclk or negedge irstn) begin
    if (!irstn) begin
      state     <= IDLE;
      shift_q   <= '0;
      idx       <= '0;
      ones      <= '0;
      gap       <= '0;
      o_data    <= '0;
      o_bit_cnt <= '0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            state   <= RECV;
            shift_q <= '0;
            idx     <= '0;
            ones    <= '0;
            gap     <= '0;
            o_busy  <= 1'b1;
          end
        end
        RECV: begin
          if (i_valid) begin
            shift_q <= shift_nxt[DATA_W-1:1];
            ones    <= ones + CNT_W'(i_sbit);
            gap     <= '0;
            if (idx == IW'(DATA_W - 1)) begin
              o_data    <= shift_nxt;
              o_bit_cnt <= ones + CNT_W'(i_sbit);
              o_done    <= 1'b1;
              state     <= DONE;
            end else begin
              idx <= idx + IW'(1);
            end
          end else if (gap == GW'(TMO - 1)) begin
            // Stalled frame: drop the partial word, keep the last good result.
            o_err  <= 1'b1;
            o_busy <= 1'b0;
            state  <= IDLE;
          end else begin
            gap <= gap + GW'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_serial_bit_receiver.sv
// Self-checking bench: a default 8-bit receiver and a 16-bit/TMO=4 receiver, driven with
// random gaps and words and checked against expected words and ones counts derived from the sent bits.
module tb_fsm_serial_bit_receiver;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;

  logic        a_start = 1'b0, a_valid = 1'b0, a_sbit = 1'b0;
  logic [7:0]  a_data;
  logic [3:0]  a_cnt;
  logic        a_done, a_err, a_busy;

  logic        b_start = 1'b0, b_valid = 1'b0, b_sbit = 1'b0;
  logic [15:0] b_data;
  logic [4:0]  b_cnt;
  logic        b_done, b_err, b_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fsm_serial_bit_receiver #(.DATA_W(8), .CNT_W(4), .TMO(15)) dut_a (
    .iclk(clk), .irstn(rstn), .i_start(a_start), .i_valid(a_valid), .i_sbit(a_sbit),
    .o_data(a_data), .o_bit_cnt(a_cnt), .o_done(a_done), .o_err(a_err), .o_busy(a_busy)
  );

  fsm_serial_bit_receiver #(.DATA_W(16), .CNT_W(5), .TMO(4)) dut_b (
    .iclk(clk), .irstn(rstn), .i_start(b_start), .i_valid(b_valid), .i_sbit(b_sbit),
    .o_data(b_data), .o_bit_cnt(b_cnt), .o_done(b_done), .o_err(b_err), .o_busy(b_busy)
  );

  // Sends one 8-bit frame on dut_a; gap < 0 means random gaps up to gap_max.
  task automatic run_frame_a(input logic [7:0] word, input int gap_max, input int gap,
                             input bit mid_start, input bit valid_at_start);
    int ones;
    int g;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(word[i]);
    a_start = 1'b1;
    a_valid = valid_at_start;
    a_sbit  = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_valid = 1'b0;
    checks++;
    if (a_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_after_start: got %0b expected 1", a_busy);
    end
    for (int i = 0; i < 8; i++) begin
      g = (gap >= 0) ? gap : int'($urandom_range(gap_max, 0));
      for (int k = 0; k < g; k++) begin
        a_sbit = 1'($urandom);
        @(negedge clk);
        checks++;
        if (a_done !== 1'b0 || a_err !== 1'b0 || a_busy !== 1'b1) begin
          errors++;
          $display("[TB] FAIL gap_state: got done=%0b err=%0b busy=%0b expected 0 0 1",
                   a_done, a_err, a_busy);
        end
      end
      a_valid = 1'b1;
      a_sbit  = word[i];
      if (mid_start && i == 4) a_start = 1'b1;
      @(negedge clk);
      a_valid = 1'b0;
      a_start = 1'b0;
      if (i < 7) begin
        checks++;
        if (a_done !== 1'b0) begin
          errors++;
          $display("[TB] FAIL done_early: bit %0d got done=%0b expected 0", i, a_done);
        end
      end
    end
    checks++;
    if (a_done !== 1'b1 || a_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_pulse: got done=%0b err=%0b expected 1 0", a_done, a_err);
    end
    checks++;
    if (a_data !== word) begin
      errors++;
      $display("[TB] FAIL data: got %02h expected %02h", a_data, word);
    end
    checks++;
    if (a_cnt !== 4'(ones)) begin
      errors++;
      $display("[TB] FAIL bit_cnt: got %0d expected %0d", a_cnt, ones);
    end
    @(negedge clk);
    checks++;
    if (a_done !== 1'b0 || a_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_width: got done=%0b busy=%0b expected 0 0", a_done, a_busy);
    end
  endtask

  // Sends one 16-bit frame on dut_b with one forced 3-cycle gap.
  task automatic run_frame_b(input logic [15:0] word);
    int ones;
    int g;
    ones = 0;
    for (int i = 0; i < 16; i++) ones += int'(word[i]);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      g = (i == 5) ? 3 : int'($urandom_range(3, 0));
      repeat (g) begin
        @(negedge clk);
        checks++;
        if (b_err !== 1'b0) begin
          errors++;
          $display("[TB] FAIL wide_gap_err: got %0b expected 0", b_err);
        end
      end
      b_valid = 1'b1;
      b_sbit  = word[i];
      @(negedge clk);
      b_valid = 1'b0;
    end
    checks++;
    if (b_done !== 1'b1 || b_data !== word || b_cnt !== 5'(ones)) begin
      errors++;
      $display("[TB] FAIL wide_frame: got done=%0b data=%04h cnt=%0d expected 1 %04h %0d",
               b_done, b_data, b_cnt, word, ones);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (a_data !== 8'h00 || a_cnt !== 4'h0 || a_done !== 1'b0 || a_err !== 1'b0 || a_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_a: got data=%02h cnt=%0d done=%0b err=%0b busy=%0b expected all 0",
               a_data, a_cnt, a_done, a_err, a_busy);
    end
    checks++;
    if (b_data !== 16'h0 || b_cnt !== 5'h0 || b_done !== 1'b0 || b_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_b: got data=%04h cnt=%0d done=%0b busy=%0b expected all 0",
               b_data, b_cnt, b_done, b_busy);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_frame_a(8'hA5, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_frame_a(8'hFF, 0, 3, 1'b0, 1'b0);
    run_frame_a(8'h00, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    logic [2:0] bits;
    bits = 3'b011;
    run_frame_a(8'h3C, 0, 0, 1'b0, 1'b0);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1;
      a_sbit  = bits[i];
      @(negedge clk);
    end
    a_valid = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k < 15) begin
        checks++;
        if (a_err !== 1'b0) begin
          errors++;
          $display("[TB] FAIL err_early: idle %0d got %0b expected 0", k, a_err);
        end
      end
    end
    checks++;
    if (a_err !== 1'b1 || a_done !== 1'b0 || a_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_pulse: got err=%0b done=%0b busy=%0b expected 1 0 0",
               a_err, a_done, a_busy);
    end
    checks++;
    if (a_data !== 8'h3C || a_cnt !== 4'd4) begin
      errors++;
      $display("[TB] FAIL timeout_hold: got data=%02h cnt=%0d expected 3c 4", a_data, a_cnt);
    end
    @(negedge clk);
    checks++;
    if (a_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_width: got %0b expected 0", a_err);
    end
    run_frame_a(8'h81, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_ignored();
    for (int k = 0; k < 6; k++) begin
      a_valid = 1'($urandom);
      a_sbit  = 1'($urandom);
      @(negedge clk);
      checks++;
      if (a_busy !== 1'b0 || a_done !== 1'b0 || a_err !== 1'b0 || a_data !== 8'h81) begin
        errors++;
        $display("[TB] FAIL idle_ignore: got busy=%0b done=%0b err=%0b data=%02h expected 0 0 0 81",
                 a_busy, a_done, a_err, a_data);
      end
    end
    a_valid = 1'b0;
    run_frame_a(8'h5A, 2, -1, 1'b1, 1'b0);
    run_frame_a(8'h00, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    run_frame_a(8'h96, 0, 0, 1'b0, 1'b0);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1;
      a_sbit  = 1'b1;
      @(negedge clk);
    end
    a_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (a_data !== 8'h00 || a_cnt !== 4'h0 || a_done !== 1'b0 || a_err !== 1'b0 || a_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: got data=%02h cnt=%0d done=%0b err=%0b busy=%0b expected all 0",
               a_data, a_cnt, a_done, a_err, a_busy);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_frame_a(8'h0F, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++)
      run_frame_a(8'($urandom), 14, -1, 1'($urandom), 1'b0);
  endtask

  task automatic test_wide();
    run_frame_b(16'hFFFF);
    run_frame_b(16'($urandom));
    run_frame_b(16'hFFFF);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b_valid = 1'b1;
      b_sbit  = 1'b0;
      @(negedge clk);
      b_valid = 1'b0;
      if (i == 1) repeat (3) @(negedge clk);
    end
    checks++;
    if (b_err !== 1'b0 || b_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wide_gap3: got err=%0b busy=%0b expected 0 1", b_err, b_busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (b_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wide_err_early: got %0b expected 0", b_err);
    end
    @(negedge clk);
    checks++;
    if (b_err !== 1'b1 || b_busy !== 1'b0 || b_done !== 1'b0 || b_data !== 16'hFFFF || b_cnt !== 5'd16) begin
      errors++;
      $display("[TB] FAIL wide_timeout: got err=%0b busy=%0b done=%0b data=%04h cnt=%0d expected 1 0 0 ffff 16",
               b_err, b_busy, b_done, b_data, b_cnt);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_ignored();
    test_reset_mid();
    test_random();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
